// File: rtl/counting_pattern_gen_pkg.sv
// Shared definitions for the counting pattern generator.
//   state_t   : FSM encoding (IDLE / SCAN / EMIT / DONE), 2 bits
//   PATTERN_W : width of an enumerated pattern {d,c,b,a}
//   COUNT_W   : width of a set-bit count and of the emitted counter
package counting_pattern_gen_pkg;

    localparam int PATTERN_W = 4;
    localparam int COUNT_W   = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_EMIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/counting_signals.sv
// Combinational popcount of four single-bit signals.
//   a, b, c, d : inputs to be counted
//   count      : number of inputs that are high (0..4)
module counting_signals
    import counting_pattern_gen_pkg::*;
(
    input  logic               a,
    input  logic               b,
    input  logic               c,
    input  logic               d,
    output logic [COUNT_W-1:0] count
);

    assign count = COUNT_W'(a) + COUNT_W'(b) + COUNT_W'(c) + COUNT_W'(d);

endmodule

// File: rtl/counting_pattern_gen.sv
// Enumerates, in ascending order, every 4-bit pattern {d,c,b,a} whose
// popcount equals a requested target, over a valid/ready handshake.
//   clk, rst     : clock, asynchronous active-high reset
//   start        : begin a new enumeration (honoured only when idle)
//   target_count : requested number of set bits, latched on start
//   ready        : consumer accepts the current pattern
//   valid        : a/b/c/d hold a pattern with the requested popcount
//   a, b, c, d   : pattern bits 0..3
//   busy         : enumeration in progress (any non-idle state)
//   done         : one-cycle completion pulse
//   err          : target above MAX_COUNT; held until the next start
//   emitted      : patterns accepted in the current or last run
module counting_pattern_gen
    import counting_pattern_gen_pkg::*;
#(
    parameter int MAX_COUNT = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [COUNT_W-1:0] target_count,
    input  logic               ready,
    output logic               valid,
    output logic               a,
    output logic               b,
    output logic               c,
    output logic               d,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [COUNT_W-1:0] emitted
);

    localparam logic [COUNT_W-1:0]   MAX_TGT   = COUNT_W'(MAX_COUNT);
    localparam logic [PATTERN_W-1:0] LAST_SCAN = '1;

    state_t                 state_reg;
    state_t                 state_next;
    logic [COUNT_W-1:0]     tgt_reg;
    logic [PATTERN_W-1:0]   scan_reg;
    logic [PATTERN_W-1:0]   pattern_reg;
    logic [COUNT_W-1:0]     emitted_reg;
    logic                   err_reg;
    logic [COUNT_W-1:0]     scan_count;
    logic                   scan_match;
    logic                   scan_last;
    logic                   target_bad;

    counting_signals u_popcount (
        .a     (scan_reg[0]),
        .b     (scan_reg[1]),
        .c     (scan_reg[2]),
        .d     (scan_reg[3]),
        .count (scan_count)
    );

    assign scan_match = (scan_count == tgt_reg);
    assign scan_last  = (scan_reg == LAST_SCAN);
    assign target_bad = (target_count > MAX_TGT);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next = target_bad ? ST_DONE : ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (scan_match) begin
                    state_next = ST_EMIT;
                end else if (scan_last) begin
                    state_next = ST_DONE;
                end
            end
            ST_EMIT: begin
                if (ready) begin
                    state_next = scan_last ? ST_DONE : ST_SCAN;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Datapath: scan cursor, latched target, captured pattern, counters.
    // The cursor stops at 15; termination is decided by scan_last rather
    // than by letting it wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tgt_reg     <= '0;
            scan_reg    <= '0;
            pattern_reg <= '0;
            emitted_reg <= '0;
            err_reg     <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        tgt_reg     <= target_count;
                        scan_reg    <= '0;
                        emitted_reg <= '0;
                        err_reg     <= target_bad;
                    end
                end
                ST_SCAN: begin
                    if (scan_match) begin
                        pattern_reg <= scan_reg;
                    end else if (!scan_last) begin
                        scan_reg <= scan_reg + 1'b1;
                    end
                end
                ST_EMIT: begin
                    if (ready) begin
                        emitted_reg <= emitted_reg + 1'b1;
                        if (!scan_last) begin
                            scan_reg <= scan_reg + 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Status outputs decode straight from the state register, so an
    // asynchronous reset clears them immediately.
    assign valid   = (state_reg == ST_EMIT);
    assign busy    = (state_reg != ST_IDLE);
    assign done    = (state_reg == ST_DONE);
    assign err     = err_reg;
    assign emitted = emitted_reg;
    assign a       = pattern_reg[0];
    assign b       = pattern_reg[1];
    assign c       = pattern_reg[2];
    assign d       = pattern_reg[3];

endmodule

// File: tb/tb_counting_pattern_gen.sv
// Scoreboard bench for counting_pattern_gen: expected patterns are queued
// when a run starts and popped on every valid/ready handshake. A second
// counting_signals instance loops the outputs back to confirm popcount.
module tb_counting_pattern_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [2:0] target_count;
    logic       ready;
    logic       valid;
    logic       a, b, c, d;
    logic       busy;
    logic       done;
    logic       err;
    logic [2:0] emitted;
    logic [2:0] loop_count;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [3:0] exp_q[$];
    logic [3:0] exp_pat;
    logic [3:0] held_pat;
    bit         held   = 1'b0;
    bit         mon_en = 1'b0;
    int         cur_tgt = 0;
    int         hs_count = 0;

    wire [3:0] pat = {d, c, b, a};

    counting_pattern_gen #(.MAX_COUNT(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .target_count (target_count),
        .ready        (ready),
        .valid        (valid),
        .a            (a),
        .b            (b),
        .c            (c),
        .d            (d),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .emitted      (emitted)
    );

    counting_signals u_loop (
        .a     (a),
        .b     (b),
        .c     (c),
        .d     (d),
        .count (loop_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        total_cnt++;
        if (obs == exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor on the falling edge, away from the active edge
    always @(negedge clk) begin
        if (mon_en && valid) begin
            check("loopback", int'(loop_count), cur_tgt);
            if (held) check("stable", int'(pat), int'(held_pat));
            if (ready) begin
                check("emitted_pre_hs", int'(emitted), hs_count);
                hs_count++;
                if (exp_q.size() == 0) begin
                    check("extra_pattern", 1, 0);
                end else begin
                    exp_pat = exp_q.pop_front();
                    check("pattern", int'(pat), int'(exp_pat));
                    $display("handshake tgt=%0d pattern=%b expected=%b emitted=%0d",
                             cur_tgt, pat, exp_pat, emitted);
                end
            end
        end
        held     = mon_en && valid && !ready;
        held_pat = pat;
    end

    // mode 0: ready always high; mode 1: ready cycles 0,0,1
    task automatic run(input int n, input int mode, input bit mid_start);
        int first_valid = -1;
        int first_idx   = -1;
        int last_idx    = 0;
        int cnt         = 0;
        int done_c      = -1;
        exp_q.delete();
        for (int p = 0; p < 16; p++) begin
            if ($countones(p[3:0]) == n) begin
                exp_q.push_back(p[3:0]);
                cnt++;
                if (first_idx < 0) first_idx = p;
                last_idx = p;
            end
        end
        cur_tgt      = n;
        hs_count     = 0;
        mon_en       = 1'b1;
        target_count = 3'(n);
        ready        = (mode == 0);
        start        = 1'b1;
        tick();
        start = 1'b0;
        for (int cy = 0; cy < 200; cy++) begin
            if (done) begin
                done_c = cy;
                break;
            end
            if (valid && first_valid < 0) first_valid = cy;
            if (mid_start) begin
                start        = (cy == 5) || (cy == 9);
                target_count = (cy == 5) ? 3'd0 : 3'(n);
            end
            ready = (mode == 0) ? 1'b1 : ((cy % 3) == 2);
            tick();
        end
        start = 1'b0;
        check("done_seen", int'(done_c >= 0), 1);
        check("emitted_final", int'(emitted), cnt);
        check("err", int'(err), int'(n > 4));
        check("queue_empty", exp_q.size(), 0);
        if (cnt > 0) begin
            check("first_valid_cycle", first_valid, first_idx + 1);
            check("hold_pattern", int'(pat), last_idx);
        end else begin
            check("valid_never", first_valid, -1);
            check("err_done_cycle", done_c, 0);
        end
        tick();
        check("done_one_cycle", int'(done), 0);
        check("busy_idle", int'(busy), 0);
        $display("run tgt=%0d mode=%0d emitted=%0d err=%0d done_cycle=%0d",
                 n, mode, emitted, err, done_c);
        mon_en = 1'b0;
        ready  = 1'b0;
    endtask

    initial begin
        rst          = 1'b1;
        start        = 1'b0;
        ready        = 1'b0;
        target_count = 3'd0;
        tick();
        tick();
        check("rst_valid", int'(valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_err", int'(err), 0);
        check("rst_pattern", int'(pat), 0);
        check("rst_emitted", int'(emitted), 0);

        // rst wins over a simultaneous start
        start = 1'b1;
        tick();
        check("rst_start_busy", int'(busy), 0);
        rst   = 1'b0;
        start = 1'b0;
        tick();
        check("after_rst_busy", int'(busy), 0);

        run(0, 0, 1'b0);
        run(2, 0, 1'b1);
        run(4, 0, 1'b0);
        run(1, 1, 1'b0);
        run(5, 0, 1'b0);

        // Reset while a target-3 pattern is waiting in EMIT
        cur_tgt      = 3;
        mon_en       = 1'b0;
        target_count = 3'd3;
        ready        = 1'b0;
        start        = 1'b1;
        tick();
        start = 1'b0;
        for (int cy = 0; cy < 40 && !valid; cy++) tick();
        check("pre_reset_valid", int'(valid), 1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_valid", int'(valid), 0);
        check("async_rst_pattern", int'(pat), 0);
        check("async_rst_busy", int'(busy), 0);
        check("async_rst_emitted", int'(emitted), 0);
        $display("reset mid-emit valid=%0d pattern=%b busy=%0d", valid, pat, busy);
        tick();
        rst = 1'b0;
        tick();

        run(3, 0, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
